// File: rtl/vga_circle_render.sv
// Draws one circle (filled disc or outline) on a VGA-style raster. Circle parameters
// are double-buffered and only take effect at the first pixel of a frame.
module vga_circle_render #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COORD_W  = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [COORD_W-1:0] i_cx,
    input  logic [COORD_W-1:0] i_cy,
    input  logic [COORD_W-1:0] i_r,
    input  logic [2:0]         i_color,
    input  logic               i_fill,
    input  logic               i_load,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_red,
    output logic               o_grn,
    output logic               o_blu,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic               o_frame_start,
    output logic               o_pending
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D2_W    = 2 * COORD_W + 2;

    localparam logic [3:0]         DIV_LOAD = 4'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_ON    = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_OFF   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_ON    = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_OFF   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic [COORD_W-1:0] r;
        logic [2:0]         color;
        logic               fill;
    } circle_t;

    logic [3:0]         div_q, div_d;
    logic [COORD_W-1:0] hx_q, hx_d, vy_q, vy_d;
    circle_t            pset_q, pset_d, aset_q, aset_d, use_set;
    logic               pend_q, pend_d, fs_q, fs_d;
    logic               pix_en, apply;

    logic signed [D2_W-1:0] dx, dy;
    logic [D2_W-1:0]        r_ext, r2, d2, rr;
    logic [D2_W-1:0]        s1_d2_q, s1_d2_d, s1_rr_q, s1_rr_d;
    logic [COORD_W-1:0]     s1_r_q, s1_r_d;
    logic [2:0]             s1_col_q, s1_col_d, rgb_q, rgb_d;
    logic                   s1_fill_q, s1_fill_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic                   s1_hb_q, s1_hb_d, s1_vb_q, s1_vb_d;
    logic                   hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, hit;

    always_comb begin
        pix_en = (div_q == 4'd0);
        div_d  = pix_en ? DIV_LOAD : div_q - 4'd1;

        hx_d = hx_q;
        vy_d = vy_q;
        if (pix_en) begin
            if (hx_q == H_LAST) begin
                hx_d = '0;
                vy_d = (vy_q == V_LAST) ? '0 : vy_q + ONE;
            end else begin
                hx_d = hx_q + ONE;
            end
        end

        // Apply happens at the origin pixel; that pixel already uses the new set.
        apply   = pix_en && (hx_q == '0) && (vy_q == '0) && pend_q;
        aset_d  = apply ? pset_q : aset_q;
        use_set = apply ? pset_q : aset_q;
        fs_d    = apply;
        pset_d  = i_load ? circle_t'{i_cx, i_cy, i_r, i_color, i_fill} : pset_q;
        pend_d  = i_load ? 1'b1 : (apply ? 1'b0 : pend_q);

        dx    = $signed(D2_W'(hx_q)) - $signed(D2_W'(use_set.cx));
        dy    = $signed(D2_W'(vy_q)) - $signed(D2_W'(use_set.cy));
        d2    = $unsigned(dx * dx + dy * dy);
        r_ext = D2_W'(use_set.r);
        rr    = r_ext * r_ext;

        s1_d2_d   = s1_d2_q;
        s1_rr_d   = s1_rr_q;
        s1_r_d    = s1_r_q;
        s1_col_d  = s1_col_q;
        s1_fill_d = s1_fill_q;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        s1_hb_d   = s1_hb_q;
        s1_vb_d   = s1_vb_q;
        if (pix_en) begin
            s1_d2_d   = d2;
            s1_rr_d   = rr;
            s1_r_d    = use_set.r;
            s1_col_d  = use_set.color;
            s1_fill_d = use_set.fill;
            s1_hs_d   = (hx_q >= HS_ON) && (hx_q < HS_OFF);
            s1_vs_d   = (vy_q >= VS_ON) && (vy_q < VS_OFF);
            s1_hb_d   = (hx_q >= H_VIS);
            s1_vb_d   = (vy_q >= V_VIS);
        end

        // Ring test written as rr <= d2 + r to avoid an underflowing subtraction.
        r2  = D2_W'(s1_r_q);
        hit = s1_fill_q ? (s1_d2_q <= s1_rr_q)
                        : ((s1_d2_q + r2 >= s1_rr_q) && (s1_d2_q <= s1_rr_q + r2));

        hs_d  = hs_q;
        vs_d  = vs_q;
        hb_d  = hb_q;
        vb_d  = vb_q;
        rgb_d = rgb_q;
        if (pix_en) begin
            hs_d  = s1_hs_q ? SYNC_POL : ~SYNC_POL;
            vs_d  = s1_vs_q ? SYNC_POL : ~SYNC_POL;
            hb_d  = s1_hb_q;
            vb_d  = s1_vb_q;
            rgb_d = (hit && !s1_hb_q && !s1_vb_q) ? s1_col_q : 3'b000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q     <= '0;
            hx_q      <= '0;
            vy_q      <= '0;
            pset_q    <= '0;
            aset_q    <= '0;
            pend_q    <= 1'b0;
            fs_q      <= 1'b0;
            s1_d2_q   <= '0;
            s1_rr_q   <= '0;
            s1_r_q    <= '0;
            s1_col_q  <= '0;
            s1_fill_q <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_hb_q   <= 1'b0;
            s1_vb_q   <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            hb_q      <= 1'b0;
            vb_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            div_q     <= div_d;
            hx_q      <= hx_d;
            vy_q      <= vy_d;
            pset_q    <= pset_d;
            aset_q    <= aset_d;
            pend_q    <= pend_d;
            fs_q      <= fs_d;
            s1_d2_q   <= s1_d2_d;
            s1_rr_q   <= s1_rr_d;
            s1_r_q    <= s1_r_d;
            s1_col_q  <= s1_col_d;
            s1_fill_q <= s1_fill_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_hb_q   <= s1_hb_d;
            s1_vb_q   <= s1_vb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            hb_q      <= hb_d;
            vb_q      <= vb_d;
            rgb_q     <= rgb_d;
        end
    end

    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_red         = rgb_q[2];
    assign o_grn         = rgb_q[1];
    assign o_blu         = rgb_q[0];
    assign o_hblank      = hb_q;
    assign o_vblank      = vb_q;
    assign o_frame_start = fs_q;
    assign o_pending     = pend_q;
endmodule
